seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor: a WIDTH-bit operation is computed DIGIT bits per clock through one shared DIGIT-wide ripple-carry slice.
- Trades latency for area; used wherever a wide add/sub is needed without a full-width carry chain.
- Start/busy/done handshake; carry-out and signed overflow flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; STEPS = WIDTH/DIGIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0: a+b+ci; 1: a-b (a + ~b + 1, ci ignored).
- ci  in  1  carry-in for add mode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result.
- co  out  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB xor carry out of MSB.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, co, ovf are 0; sum is 0; internal shift registers and carry are 0. Takes effect immediately, including mid-RUN; a partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN when start=1 at a clock edge.
  - RUN to DONE after exactly STEPS edges in RUN.
  - DONE to IDLE unconditionally on the next edge.
- On start acceptance:
  - Latch a into A-reg.
  - Latch (sub ? ~b : b) into B-reg.
  - Carry register = sub ? 1 : ci.
  - Clear step counter.
  - a, b, ci and sub are ignored afterwards until the next acceptance.
- Each RUN cycle:
  - The slice adds A-reg[DIGIT-1:0], B-reg[DIGIT-1:0] and the carry.
  - Carry register takes the slice carry-out.
  - A-reg and B-reg shift right by DIGIT.
  - Slice sum enters the top DIGIT bits of the result shift register, which shifts right by DIGIT.
  - Counter increments.
- Last RUN cycle (counter = STEPS-1):
  - Additionally capture co = slice carry-out.
  - Capture ovf = slice carry-into-top-bit xor slice carry-out.
- Latency: start sampled at edge t0. busy=1 from t0 to t0+STEPS. done=1 for exactly one cycle, from edge t0+STEPS to t0+STEPS+1. sum/co/ovf are valid from t0+STEPS.
- sum, co and ovf hold their values until the next accepted start. On acceptance, co and ovf clear to 0 and sum keeps its old value until overwritten by shifting.
- start while in RUN or DONE is ignored; it is not queued. Maximum throughput is one operation per STEPS+2 cycles when start is held high.
- Degenerate case DIGIT = WIDTH (STEPS = 1): RUN lasts one cycle and done asserts one cycle after start.
- Counter width is clog2(STEPS), minimum 1 bit. Wrap-around never occurs because RUN exits at STEPS-1.
- All arithmetic is unsigned modulo 2^WIDTH; ovf interprets operands as signed.

Decomposition:
- Shared package / include file: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the clog2 helper function.
- One sub-module, addsub_slice: a combinational DIGIT-wide ripple-carry adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, cmsb (carry into the top bit).
  - Built from per-bit full adders.
- The top level contains the FSM, counter, shift registers and flag capture.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
- Add: a=0x1234, b=0x4321, ci=0, sub=0, start for 1 cycle -> busy high 4 cycles; done pulses exactly 4 cycles after start; sum=0x5555, co=0, ovf=0.
- Carry/overflow: 0xFFFF+0x0001 -> sum=0x0000, co=1, ovf=0. 0x7FFF+0x0001 -> sum=0x8000, co=0, ovf=1. 0x0000+0x0000 with ci=1 -> sum=0x0001.
- Subtract: 0x0005-0x0007 -> sum=0xFFFE, co=0, ovf=0. 0x8000-0x0001 -> sum=0x7FFF, co=1, ovf=1.
- Handshake: start held high continuously -> accepted every 6 cycles. New start plus changed a/b during RUN -> ignored and result unchanged. sum remains stable after done until the next start.
- Reset mid-operation: rst_n low during the 2nd RUN cycle -> busy/done/sum/co/ovf become 0 immediately with no done pulse. After release, a new start with 0x0001+0x0001 gives 0x0002.
- Parameter sweep: WIDTH=8/DIGIT=8 -> done 1 cycle after start, 0xFF+0x01 gives sum=0x00, co=1. WIDTH=32/DIGIT=1 -> done after 32 cycles; random operands checked against a + b model.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and
// the counter-width helper.
package seq_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) r++;
      return r;
   endfunction

   // Step counter needs at least one bit even when a single step suffices.
   function automatic int unsigned cnt_width(input int unsigned steps);
      return (clog2(steps) < 1) ? 1 : clog2(steps);
   endfunction

endpackage

// File: rtl/seq_addsub_slice.sv
// DIGIT-wide ripple-carry slice built from per-bit full adders; also exposes
// the carry into its top bit for overflow detection.
module addsub_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign cout = c[DIGIT];
   assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit add or subtract computed DIGIT bits
// per clock through one shared ripple-carry slice, with start/busy/done.
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             ci,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = cnt_width(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0]       s;
   logic                   cout;
   logic                   cmsb;
   logic [WIDTH+DIGIT-1:0] res_cat;

   addsub_slice #(.DIGIT(DIGIT)) u_slice (
      .x    (areg[DIGIT-1:0]),
      .y    (breg[DIGIT-1:0]),
      .cin  (carry),
      .s    (s),
      .cout (cout),
      .cmsb (cmsb)
   );

   // Concatenation keeps the result shift legal even when DIGIT == WIDTH.
   assign res_cat = {s, res};
   assign sum     = res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         areg  <= '0;
         breg  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         co    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  areg  <= a;
                  breg  <= sub ? ~b : b;
                  carry <= sub | ci;
                  cnt   <= '0;
                  co    <= 1'b0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               carry <= cout;
               areg  <= areg >> DIGIT;
               breg  <= breg >> DIGIT;
               res   <= res_cat[WIDTH+DIGIT-1:DIGIT];
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  co    <= cout;
                  ovf   <= cmsb ^ cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub at three parameter points (16/4, 8/8, 32/1).
module tb_seq_addsub;

   typedef struct {
      int          dut;
      logic [31:0] sum;
      logic        co;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   logic [31:0] opa    [3];
   logic [31:0] opb    [3];
   logic        ostart [3];
   logic        osub   [3];
   logic        oci    [3];
   logic        dn     [3];
   logic        bs     [3];
   logic        cov    [3];
   logic        ovv    [3];
   logic [31:0] sm     [3];
   logic [15:0] s16;
   logic [7:0]  s8;
   logic [31:0] s32;
   int          dcount [3];
   logic [31:0] last_sum [3];

   localparam int WID [3] = '{16, 8, 32};
   localparam int STP [3] = '{4, 1, 32};

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_addsub #(.WIDTH(16), .DIGIT(4)) d16 (
      .clk(clk), .rst_n(rst_n), .start(ostart[0]), .sub(osub[0]), .ci(oci[0]),
      .a(opa[0][15:0]), .b(opb[0][15:0]), .busy(bs[0]), .done(dn[0]),
      .sum(s16), .co(cov[0]), .ovf(ovv[0]));

   seq_addsub #(.WIDTH(8), .DIGIT(8)) d8 (
      .clk(clk), .rst_n(rst_n), .start(ostart[1]), .sub(osub[1]), .ci(oci[1]),
      .a(opa[1][7:0]), .b(opb[1][7:0]), .busy(bs[1]), .done(dn[1]),
      .sum(s8), .co(cov[1]), .ovf(ovv[1]));

   seq_addsub #(.WIDTH(32), .DIGIT(1)) d32 (
      .clk(clk), .rst_n(rst_n), .start(ostart[2]), .sub(osub[2]), .ci(oci[2]),
      .a(opa[2]), .b(opb[2]), .busy(bs[2]), .done(dn[2]),
      .sum(s32), .co(cov[2]), .ovf(ovv[2]));

   assign sm[0] = {16'h0, s16};
   assign sm[1] = {24'h0, s8};
   assign sm[2] = s32;

   task automatic check(input string nm, input longint got, input longint expv);
      tests++;
      if (got != expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, expv);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sub);
      exp_t         e;
      longint unsigned m, ua, ub, ur;
      longint       sa, sb, sr, half;
      m    = 64'd1 << w;
      half = longint'(m / 2);
      ua   = longint'(a) & (m - 1);
      ub   = longint'(b) & (m - 1);
      sa   = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
      sb   = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
      if (sub) begin
         ur   = (ua + m - ub) % m;
         e.co = (ua >= ub);
         sr   = sa - sb;
      end else begin
         ur   = ua + ub + longint'(ci);
         e.co = (ur >= m);
         ur   = ur % m;
         sr   = sa + sb + longint'(ci);
      end
      e.ovf = (sr < -half) || (sr >= half);
      e.sum = 32'(ur);
      e.dut = 0;
      e.cyc = 0;
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         if (dn[d]) begin
            dcount[d]++;
            if (q.size() == 0 || q[0].dut != d) begin
               check($sformatf("spurious_done_dut%0d", d), 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check($sformatf("sum_dut%0d", d), sm[d], e.sum);
               check($sformatf("co_dut%0d", d), cov[d], e.co);
               check($sformatf("ovf_dut%0d", d), ovv[d], e.ovf);
               check($sformatf("latency_dut%0d", d), cyc - e.cyc, STP[d]);
               check($sformatf("busy_at_done_dut%0d", d), bs[d], 0);
            end
         end
      end
   end

   function automatic logic [31:0] mask(input int d);
      return (WID[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << WID[d]) - 32'h1);
   endfunction

   task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sub, input int acc);
      exp_t e;
      e = model(WID[d], a, b, ci, sub);
      e.dut = d;
      e.cyc = acc;
      q.push_back(e);
      last_sum[d] = e.sum;
   endtask

   task automatic op(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic sub);
      int bc, n;
      @(negedge clk);
      opa[d] = a & mask(d); opb[d] = b & mask(d); oci[d] = ci; osub[d] = sub;
      ostart[d] = 1'b1;
      push_exp(d, a & mask(d), b & mask(d), ci, sub, cyc + 1);
      @(negedge clk);
      ostart[d] = 1'b0;
      check("flags_clear_on_accept", {cov[d], ovv[d]}, 0);
      bc = 0; n = 0;
      while (!dn[d] && n < 200) begin
         if (bs[d]) bc++;
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("done_timeout", 0, 1);
      check("busy_cycles", bc, STP[d]);
   endtask

   task automatic wait_empty(input int limit);
      int n;
      n = 0;
      while (q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", q.size(), 0);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int base;
      for (int d = 0; d < 3; d++) begin
         opa[d] = '0; opb[d] = '0; ostart[d] = 1'b0; osub[d] = 1'b0; oci[d] = 1'b0;
         dcount[d] = 0; last_sum[d] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_busy", bs[d], 0);
         check("reset_done", dn[d], 0);
         check("reset_sum", sm[d], 0);
         check("reset_flags", {cov[d], ovv[d]}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Directed 16/4 vectors
      op(0, 32'h1234, 32'h4321, 1'b0, 1'b0);
      op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
      op(0, 32'h0000, 32'h0000, 1'b1, 1'b0);
      op(0, 32'h0005, 32'h0007, 1'b0, 1'b1);
      op(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
      op(0, 32'h1234, 32'h1234, 1'b1, 1'b1);

      // Result holds after done
      repeat (5) begin
         @(negedge clk);
         check("sum_stable", sm[0], last_sum[0]);
      end

      // Start and operand changes during RUN are ignored
      @(negedge clk);
      opa[0] = 32'h0F0F; opb[0] = 32'h00F1; oci[0] = 1'b0; osub[0] = 1'b0; ostart[0] = 1'b1;
      push_exp(0, 32'h0F0F, 32'h00F1, 1'b0, 1'b0, cyc + 1);
      @(negedge clk);
      ostart[0] = 1'b0;
      @(negedge clk);
      opa[0] = 32'hAAAA; opb[0] = 32'h5555; osub[0] = 1'b1; oci[0] = 1'b1; ostart[0] = 1'b1;
      @(negedge clk);
      ostart[0] = 1'b0;
      wait_empty(50);
      base = dcount[0];
      repeat (12) @(negedge clk);
      check("no_extra_done", dcount[0] - base, 0);
      check("sum_after_ignored_start", sm[0], last_sum[0]);

      // Start held high: one acceptance every STEPS+2 cycles
      @(negedge clk);
      opa[0] = 32'h3000; opb[0] = 32'h0456; oci[0] = 1'b1; osub[0] = 1'b0; ostart[0] = 1'b1;
      for (int k = 0; k < 3; k++)
         push_exp(0, 32'h3000, 32'h0456, 1'b1, 1'b0, cyc + 1 + k * (STP[0] + 2));
      repeat (2 * (STP[0] + 2) + 1) @(negedge clk);
      ostart[0] = 1'b0;
      wait_empty(50);
      repeat (10) @(negedge clk);
      check("held_start_done_count", dcount[0] - base, 3);

      // Reset in the second RUN cycle discards the operation
      op(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
      @(negedge clk);
      opa[0] = 32'h1111; opb[0] = 32'h2222; oci[0] = 1'b0; osub[0] = 1'b0; ostart[0] = 1'b1;
      @(negedge clk);
      ostart[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", bs[0], 0);
      check("midrun_rst_done", dn[0], 0);
      check("midrun_rst_sum", sm[0], 0);
      check("midrun_rst_co", cov[0], 0);
      check("midrun_rst_ovf", ovv[0], 0);
      base = dcount[0];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("no_done_after_rst", dcount[0] - base, 0);
      op(0, 32'h0001, 32'h0001, 1'b0, 1'b0);

      // Random 16/4
      repeat (40) op(0, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));

      // 8/8 single-step case
      op(1, 32'hFF, 32'h01, 1'b0, 1'b0);
      op(1, 32'h7F, 32'h01, 1'b0, 1'b0);
      op(1, 32'h00, 32'h01, 1'b0, 1'b1);
      repeat (10) op(1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));

      // 32/1 bit-serial case
      op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      op(2, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
      repeat (20) op(2, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));

      wait_empty(100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got %0d tests expected completion", tests);
      $fatal(1, "timeout");
   end

endmodule
